// File: rtl/calc_pkg.sv
// ------------------------------------------------------------------------------
// calc_pkg: shared types, constants and helpers for calc_sequencer  (rev 1.0)
// ------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  localparam int OPW       = 7;
  localparam int RESW      = 2 * OPW;
  localparam int BCDW      = 16;
  localparam int EXEC_ITER = 7;
  localparam int CONV_ITER = 14;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Out-of-range digits clamp to 9 before the two-digit operand is formed.
  function automatic logic [OPW-1:0] bcd_pair(input logic [3:0] hi, input logic [3:0] lo);
    logic [OPW-1:0] h;
    logic [OPW-1:0] l;
    h = (hi > 4'd9) ? OPW'(9) : OPW'(hi);
    l = (lo > 4'd9) ? OPW'(9) : OPW'(lo);
    return OPW'(h * OPW'(10) + l);
  endfunction

  // Lowest set select bit wins.
  function automatic op_t op_decode(input logic [3:0] sel);
    if (sel[0])      return OP_ADD;
    else if (sel[1]) return OP_SUB;
    else if (sel[2]) return OP_MUL;
    else             return OP_DIV;
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_sequencer_bin2bcd.sv
// ------------------------------------------------------------------------------
// bin2bcd_seq: 14-cycle shift-and-add-3 binary to 4-digit BCD converter (rev 1.0)
// ------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq #(
  parameter int BINW = 14,
  parameter int BCDW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [BINW-1:0] bin,
  output logic            done,
  output logic [BCDW-1:0] bcd
);
  import calc_pkg::*;

  localparam int SRW = BCDW + BINW;

  logic [SRW-1:0] r_sr;
  logic [3:0]     r_cnt;
  logic           r_active;
  logic [SRW-1:0] w_next;

  function automatic logic [SRW-1:0] dd_step(input logic [SRW-1:0] x);
    logic [SRW-1:0] y;
    y = x;
    for (int k = 0; k < BCDW / 4; k++) begin
      if (y[BINW + 4*k +: 4] >= 4'd5)
        y[BINW + 4*k +: 4] = y[BINW + 4*k +: 4] + 4'd3;
    end
    return {y[SRW-2:0], 1'b0};
  endfunction

  // The go edge already performs the first shift, so the whole run is CONV_ITER edges.
  assign w_next = dd_step(go ? {{BCDW{1'b0}}, bin} : r_sr);
  assign done   = r_active && (r_cnt == 4'(CONV_ITER - 1));
  assign bcd    = w_next[SRW-1:BINW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (go) begin
      r_sr     <= w_next;
      r_cnt    <= 4'd1;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_sr  <= w_next;
      r_cnt <= r_cnt + 4'd1;
      if (done) r_active <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ------------------------------------------------------------------------------
// calc_sequencer: iterative add/sub/mul/div sequencer with registered BCD result (rev 1.0)
// ------------------------------------------------------------------------------
`default_nettype none

module calc_sequencer #(
  parameter int OPW  = 7,
  parameter int RESW = 2 * OPW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  dig0,
  input  logic [3:0]  dig1,
  input  logic [3:0]  dig2,
  input  logic [3:0]  dig3,
  input  logic [3:0]  sw,
  output logic        busy,
  output logic        valid,
  output logic [15:0] res_bcd,
  output logic        neg,
  output logic        err
);
  import calc_pkg::*;

  state_t          r_state;
  op_t             r_op;
  logic [OPW-1:0]  r_a;
  logic [OPW-1:0]  r_b;
  logic [RESW-1:0] r_mcand;
  logic [RESW-1:0] r_acc;
  logic [2:0]      r_iter;
  logic            r_go;

  logic [OPW-1:0]  w_a_in;
  logic [OPW-1:0]  w_b_in;
  logic [RESW-1:0] w_mul_acc;
  logic [OPW+1:0]  w_trial;
  logic [OPW:0]    w_rem_shift;
  logic            w_last_iter;
  logic            w_conv_done;
  logic [15:0]     w_conv_bcd;

  assign w_a_in = bcd_pair(dig3, dig2);
  assign w_b_in = bcd_pair(dig1, dig0);

  // Multiply: r_mcand is the shifting multiplicand, r_b shifts right as the multiplier.
  assign w_mul_acc = r_acc + (r_b[0] ? r_mcand : '0);

  // Divide: partial remainder lives in r_acc, dividend/quotient bits shift through r_mcand.
  assign w_rem_shift = {r_acc[OPW-1:0], r_mcand[OPW-1]};
  assign w_trial     = {1'b0, w_rem_shift} - {2'b00, r_b};
  assign w_last_iter = (r_iter == 3'(EXEC_ITER - 1));

  bin2bcd_seq #(
    .BINW (RESW),
    .BCDW (16)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .go   (r_go),
    .bin  (r_acc),
    .done (w_conv_done),
    .bcd  (w_conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_iter  <= '0;
      r_go    <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      res_bcd <= '0;
      neg     <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start && (sw != 4'd0)) begin
            r_state <= ST_EXEC;
            r_op    <= op_decode(sw);
            r_a     <= w_a_in;
            r_b     <= w_b_in;
            r_mcand <= RESW'(w_a_in);
            r_acc   <= '0;
            r_iter  <= '0;
            busy    <= 1'b1;
            valid   <= 1'b0;
            neg     <= 1'b0;
            err     <= 1'b0;
          end
        end

        ST_EXEC: begin
          r_iter <= r_iter + 3'd1;
          case (r_op)
            OP_ADD: begin
              r_acc   <= RESW'(r_a) + RESW'(r_b);
              r_go    <= 1'b1;
              r_state <= ST_CONV;
            end
            OP_SUB: begin
              r_acc   <= (r_a >= r_b) ? RESW'(r_a - r_b) : RESW'(r_b - r_a);
              neg     <= (r_a < r_b);
              r_go    <= 1'b1;
              r_state <= ST_CONV;
            end
            OP_MUL: begin
              r_acc   <= w_mul_acc;
              r_mcand <= {r_mcand[RESW-2:0], 1'b0};
              r_b     <= {1'b0, r_b[OPW-1:1]};
              if (w_last_iter) begin
                r_go    <= 1'b1;
                r_state <= ST_CONV;
              end
            end
            default: begin
              r_acc   <= w_trial[OPW+1] ? RESW'(w_rem_shift) : RESW'(w_trial[OPW:0]);
              r_mcand <= {r_mcand[RESW-2:0], ~w_trial[OPW+1]};
              if (w_last_iter) begin
                // A zero divisor still runs all iterations so timing stays uniform.
                r_acc   <= (r_b == '0) ? '0
                           : RESW'({r_mcand[OPW-2:0], ~w_trial[OPW+1]});
                err     <= (r_b == '0);
                r_go    <= 1'b1;
                r_state <= ST_CONV;
              end
            end
          endcase
        end

        ST_CONV: begin
          r_go <= 1'b0;
          if (w_conv_done) begin
            res_bcd <= w_conv_bcd;
            busy    <= 1'b0;
            valid   <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
